// File: rtl/uart_rx_bit_sampler.sv
// rtl/uart_rx_bit_sampler.sv - UART RX oversampling counters and 3-sample majority voter
// Define UART_RX_SYNC_EN to insert a 2-flop synchronizer on RX_IN ahead of the voter.
module uart_rx_bit_sampler (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic       RX_IN,
  input  logic [5:0] Prescale,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       sampled_bit,
  output logic       sample_valid
);

  logic [5:0] p_q, p_d;
  logic [5:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;
  logic       s0_q, s0_d;
  logic       s1_q, s1_d;
  logic       samp_q, samp_d;
  logic       valid_q, valid_d;
  logic       line;
  logic [5:0] half;
  logic       vote;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RX_IN};
    end
  end

  assign line = sync_q[1];
`else
  assign line = RX_IN;
`endif

  assign half = {1'b0, p_q[5:1]};
  assign vote = (s0_q & s1_q) | (s0_q & line) | (s1_q & line);

  always_comb begin
    p_d     = p_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    samp_d  = samp_q;
    valid_d = 1'b0;
    if (!enable) begin
      // Ratio is only sampled between frames; anything unsupported falls back to 16x.
      if (Prescale == 6'd8 || Prescale == 6'd16 || Prescale == 6'd32) begin
        p_d = Prescale;
      end else begin
        p_d = 6'd16;
      end
      edge_d = 6'd0;
      bit_d  = 4'd0;
    end else begin
      if (edge_q == p_q - 6'd1) begin
        edge_d = 6'd0;
        if (bit_q != 4'hF) begin
          bit_d = bit_q + 4'd1;
        end
      end else begin
        edge_d = edge_q + 6'd1;
      end
      if (edge_q == half - 6'd1) begin
        s0_d = line;
      end
      if (edge_q == half) begin
        s1_d = line;
      end
      if (edge_q == half + 6'd1) begin
        samp_d  = vote;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      p_q     <= 6'd16;
      edge_q  <= 6'd0;
      bit_q   <= 4'd0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      samp_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      samp_q  <= samp_d;
      valid_q <= valid_d;
    end
  end

  assign edge_cnt     = edge_q;
  assign bit_cnt      = bit_q;
  assign sampled_bit  = samp_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// tb/tb_uart_rx_bit_sampler.sv - scoreboard bench for uart_rx_bit_sampler
// Expected strobes come from a per-cycle line waveform and the majority rule.
module tb_uart_rx_bit_sampler;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enable;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       sample_valid;

  uart_rx_bit_sampler dut (
    .CLK          (CLK),
    .RST          (RST),
    .enable       (enable),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

`ifdef UART_RX_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  typedef struct {
    int cyc;
    int b;
    int bc;
    int ec;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic wave [0:1023];
  int   frame_bits [0:10];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int min15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Value the voter sees in enabled cycle t; before the frame the line is idle high.
  function automatic int line_at(input int t);
    if (t - D < 0) return 1;
    return (wave[t - D] === 1'b1) ? 1 : 0;
  endfunction

  always @(negedge CLK) begin
    if (sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe_cycle", cyc, -1);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_cycle", cyc, mon_e.cyc);
        check("sampled_bit", int'(sampled_bit), mon_e.b);
        check("strobe_bit_cnt", int'(bit_cnt), mon_e.bc);
        check("strobe_edge_cnt", int'(edge_cnt), mon_e.ec);
      end
    end
  end

  task automatic gen_random(input int p, input int n);
    int b, idx;
    for (int k = 0; k * p < n; k++) begin
      b = $urandom_range(0, 1);
      for (int j = 0; j < p; j++) begin
        if (k * p + j < n) wave[k * p + j] = b[0];
      end
      for (int g = 0; g < 2; g++) begin
        idx = k * p + p / 2 - 3 + $urandom_range(0, 4);
        if (idx < n) wave[idx] = ~wave[idx];
      end
    end
  endtask

  // Frame of n enabled cycles at effective ratio p; ends with enable low, or with RST high if rst_end.
  task automatic run_frame(input int p, input int n, input bit rst_end);
    int   c0, h, s;
    exp_t e;
    int   pv [6] = '{8, 16, 32, 12, 0, 63};
    h = p / 2;
    @(posedge CLK); #1;
    c0 = cyc;
    for (int k = 0; k * p + h + 2 <= n; k++) begin
      s    = line_at(k * p + h - 1) + line_at(k * p + h) + line_at(k * p + h + 1);
      e.cyc = c0 + k * p + h + 2;
      e.b   = (s >= 2) ? 1 : 0;
      e.bc  = min15(k);
      e.ec  = h + 2;
      exp_q.push_back(e);
    end
    for (int t = 0; t < n; t++) begin
      if (t > 0) begin
        @(posedge CLK); #1;
      end
      RST      = 1'b0;
      enable   = 1'b1;
      RX_IN    = wave[t];
      Prescale = 6'(pv[$urandom_range(0, 5)]);
      @(negedge CLK);
      check("edge_cnt", int'(edge_cnt), t % p);
      check("bit_cnt", int'(bit_cnt), min15(t / p));
    end
    @(posedge CLK); #1;
    RST    = rst_end;
    enable = rst_end;
    RX_IN  = 1'b1;
    @(negedge CLK);
    check("edge_cnt_last", int'(edge_cnt), n % p);
    check("bit_cnt_last", int'(bit_cnt), min15(n / p));
  endtask

  task automatic idle(input int n, input int presc);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      RST      = 1'b0;
      enable   = 1'b0;
      RX_IN    = 1'b1;
      Prescale = 6'(presc);
      @(negedge CLK);
      check("idle_edge_cnt", int'(edge_cnt), 0);
      check("idle_bit_cnt", int'(bit_cnt), 0);
    end
  endtask

  initial begin
    int tl, p, n;
    int pv [6] = '{8, 16, 32, 12, 0, 63};
    logic [7:0] data;

    RST      = 1'b1;
    enable   = 1'b1;
    RX_IN    = 1'b0;
    Prescale = 6'd8;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_edge_cnt", int'(edge_cnt), 0);
    check("reset_bit_cnt", int'(bit_cnt), 0);
    check("reset_sampled_bit", int'(sampled_bit), 1);
    check("reset_sample_valid", int'(sample_valid), 0);

    // Enabled straight out of reset: ratio is the reset value 16.
    gen_random(16, 48);
    run_frame(16, 48, 1'b0);
    idle(3, 8);

    for (int t = 0; t < 8; t++) wave[t] = 1'b0;
    run_frame(8, 8, 1'b0);
    idle(3, 16);

    for (int t = 0; t < 32; t++) begin
      tl = t + D;
      if (tl < 16) wave[t] = !(tl == 7 || tl == 9);
      else         wave[t] = (tl == 23 || tl == 25);
    end
    run_frame(16, 32, 1'b0);
    idle(3, 32);

    data = 8'hA5;
    frame_bits[0] = 0;
    for (int i = 0; i < 8; i++) frame_bits[i + 1] = int'(data[i]);
    frame_bits[9]  = int'(^data);
    frame_bits[10] = 1;
    for (int t = 0; t < 352; t++) wave[t] = frame_bits[t / 32][0];
    run_frame(32, 352, 1'b0);
    idle(3, 16);

    gen_random(16, 3 * 16 + 5);
    run_frame(16, 3 * 16 + 5, 1'b0);
    idle(3, 12);

    gen_random(16, 40);
    run_frame(16, 40, 1'b0);
    idle(3, 8);

    gen_random(8, 22);
    run_frame(8, 22, 1'b0);
    idle(3, 8);

    gen_random(8, 144);
    run_frame(8, 144, 1'b1);
    gen_random(16, 40);
    run_frame(16, 40, 1'b0);

    for (int f = 0; f < 8; f++) begin
      p = pv[$urandom_range(0, 5)];
      idle(3, p);
      p = (p == 8 || p == 16 || p == 32) ? p : 16;
      n = $urandom_range(p, 20 * p);
      gen_random(p, n);
      run_frame(p, n, 1'b0);
    end
    idle(5, 16);

    check("leftover_expected_strobes", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_bit_sampler.md
# uart_rx_bit_sampler

Oversampling front end of the UART receiver. It counts oversampling edges and bit periods while the RX FSM enables it, and takes three samples of RX_IN around the middle of each bit. A majority vote of those samples produces one sampled bit per bit period. Its `sampled_bit` and `bit_cnt` outputs drive the deserializer, parity-check and stop-check stages, qualified by the FSM using `sample_valid`.

## Interface
- No parameters.
- `CLK  in  1` — receiver clock; oversampling rate = Prescale × baud.
- `RST  in  1` — synchronous, active-high reset.
- `enable  in  1` — from the RX FSM; high while a frame is being received.
- `RX_IN  in  1` — serial line; idle high.
- `Prescale  in  6` — oversampling ratio. Legal values are 8, 16 and 32.
- `edge_cnt  out  6` — oversample index within the current bit, 0 to P−1.
- `bit_cnt  out  4` — bit index within the frame: start = 0, data = 1–8, parity = 9, stop = 9 or 10.
- `sampled_bit  out  1` — majority-voted value of the current bit.
- `sample_valid  out  1` — one-cycle strobe; `sampled_bit` is new this cycle.

## Operation
- **Reset values:** `edge_cnt` = 0, `bit_cnt` = 0, `sampled_bit` = 1, `sample_valid` = 0, internal sample registers = 1, effective prescale P = 16.
- **Prescale capture:**
  - P is a register loaded from `Prescale` on every cycle with `enable` = 0.
  - P is frozen while `enable` = 1, so `Prescale` changes mid-frame are ignored.
  - Illegal values (anything other than 8, 16, 32) load P = 16.
- **Counters:**
  - With `enable` = 0: `edge_cnt` and `bit_cnt` are held at 0, and `sample_valid` is 0 from the following cycle.
  - With `enable` = 1: `edge_cnt` increments each cycle.
  - When `edge_cnt` = P−1, it wraps to 0 and `bit_cnt` increments.
  - `bit_cnt` saturates at 15; it does not wrap.
- **Sampling** (H = P/2, all in the current bit):
  - s0 ← line at `edge_cnt` = H−1.
  - s1 ← line at `edge_cnt` = H.
  - At `edge_cnt` = H+1: `sampled_bit` ← maj(s0, s1, line), and `sample_valid` ← 1.
  - Otherwise `sample_valid` ← 0 and `sampled_bit` holds.
- **Majority rule:** `sampled_bit` = (s0&s1) | (s0&line) | (s1&line).
- **Downstream contract:** the FSM asserts deserializer enable only in cycles with `sample_valid` = 1 and `bit_cnt` in 1–8, so each data bit is written exactly once.
- **`enable` dropped mid-bit:**
  - Counters clear on the next edge.
  - A partially collected vote is discarded, and no `sample_valid` is produced for that bit.
  - s0/s1 are not cleared; they are overwritten on the next bit.
- **`enable` falls in the cycle `sample_valid` is high:** the strobe is still presented; it is already registered.
- **`RST` during operation:** all registers return to their reset values on that edge, regardless of `enable`.

## Timing
- `sampled_bit` and `sample_valid` update on the edge where `edge_cnt` goes H+1 → H+2. Both are visible while `edge_cnt` = H+2:
  - 6 for P = 8
  - 10 for P = 16
  - 18 for P = 32
- One bit period = P cycles.
- The first bit (start bit) begins in the cycle after `enable` rises: `edge_cnt` = 0 in the first enabled cycle.
- Latency from mid-bit to strobe is 2 cycles after the first vote sample. It is 4 cycles with `RX_SYNC_EN`; see Configuration.
- Frame of 11 bits at P = 16: `bit_cnt` reaches 10 after 160 enabled cycles, and the last strobe occurs at cycle 10·16 + 10.

## Configuration
- **`UART_RX_SYNC_EN` defined:**
  - RX_IN passes through a 2-flop synchronizer (reset value 1) before sampling.
  - "line" in all sampling rules is the synchronizer output.
  - The line is delayed 2 cycles relative to RX_IN; the FSM start-edge detection compensates.
- **`UART_RX_SYNC_EN` undefined:**
  - RX_IN is sampled directly. This is legal only when RX_IN is already synchronous to `CLK`.
  - No added latency.

## Test plan
- **Reset:** hold `RST` = 1 for 2 cycles with `enable` = 1 and RX_IN = 0 → `edge_cnt` = 0, `bit_cnt` = 0, `sampled_bit` = 1, `sample_valid` = 0.
- **P = 8, RX_IN = 0, enable for 8 cycles:**
  - `edge_cnt` steps 0…7.
  - `sample_valid` = 1 exactly at `edge_cnt` = 6, with `sampled_bit` = 0.
  - `bit_cnt` = 1 in cycle 9.
- **Majority, P = 16:** line 0 at edges 7 and 9, 1 at edge 8 → `sampled_bit` = 0. Line 1, 0, 1 at edges 7/8/9 → `sampled_bit` = 1. Both strobes at `edge_cnt` = 10.
- **Full frame, P = 32:**
  - Drive start bit 0, data 0xA5 LSB-first, even parity 0, then stop bit 1.
  - Strobes show 0,1,0,1,0,0,1,0,1,0,1 at `bit_cnt` 0–10.
  - `bit_cnt` = 10 after 320 cycles.
- **Abort:** drop `enable` at `edge_cnt` = 5 of bit 3 → `edge_cnt` and `bit_cnt` = 0 next cycle, and no `sample_valid` for that bit.
- **Illegal/changed prescale:**
  - `Prescale` = 12 → bit period 16 cycles.
  - Changing `Prescale` 16 → 8 while enabled → period stays 16 until `enable` drops.
  - With `UART_RX_SYNC_EN`, a RX_IN edge is seen by the vote 2 cycles later.
